// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the pwm ramp sequencer
package pwm_pkg;

    localparam int N_DEF = 16;
    localparam int D_DEF = 24;

    // Duty value that keeps the accumulator generator low; truncated to N bits at use.
    localparam logic [31:0] DUTY_PARK = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } pwm_state_e;

endpackage

// File: rtl/pwm_dwell_timer.sv
// rtl/pwm_dwell_timer.sv - loadable down-counter timing ramp steps and holds
module pwm_dwell_timer
    import pwm_pkg::*;
#(
    parameter int D = D_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [D-1:0] load_value,
    input  logic         enable,
    output logic         zero
);

    logic [D-1:0] r_count;

    // Load wins over decrement; the count parks at zero until reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - breathing-profile sequencer for the accumulator pwm generator
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int D = D_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [N-1:0] cfg_period,
    input  logic [N-1:0] cfg_duty_min,
    input  logic [N-1:0] cfg_duty_max,
    input  logic [N-1:0] cfg_step,
    input  logic [D-1:0] cfg_dwell,
    input  logic [D-1:0] cfg_hold,
    input  logic         start,
    input  logic         stop,
    input  logic         abort,
    output logic [N-1:0] period,
    output logic [N-1:0] duty,
    output logic         busy,
    output logic         cycle_done
);

    pwm_state_e   r_state;
    pwm_state_e   w_state_nxt;

    logic [N-1:0] r_cfg_period;
    logic [N-1:0] r_cfg_min;
    logic [N-1:0] r_cfg_max;
    logic [N-1:0] r_cfg_step;
    logic [D-1:0] r_cfg_dwell;
    logic [D-1:0] r_cfg_hold;

    logic [N-1:0] r_period;
    logic [N-1:0] r_duty;
    logic         r_busy;
    logic         r_cycle_done;
    logic         r_cfg_ready;
    logic         r_stop_pending;

    logic [N-1:0] w_period_nxt;
    logic [N-1:0] w_duty_nxt;
    logic         w_done_nxt;
    logic         w_stop_pending_nxt;
    logic         w_load;
    logic [D-1:0] w_load_value;
    logic         w_zero;

    logic         w_accept;
    logic         w_start;
    logic [N-1:0] w_max_in;
    logic [N-1:0] w_step_in;
    logic [N:0]   w_sum;
    logic [N:0]   w_diff;
    logic         w_rise_sat;
    logic         w_fall_sat;

    assign w_accept   = cfg_valid & r_cfg_ready;
    assign w_start    = start & (r_state == ST_IDLE) & ~w_accept;
    assign w_max_in   = (cfg_duty_min > cfg_duty_max) ? cfg_duty_min : cfg_duty_max;
    assign w_step_in  = (cfg_step == '0) ? {{(N-1){1'b0}}, 1'b1} : cfg_step;

    // Extra bit on both sides so a step past either rail never wraps.
    assign w_sum      = {1'b0, r_duty} + {1'b0, r_cfg_step};
    assign w_diff     = {1'b0, r_duty} - {1'b0, r_cfg_step};
    assign w_rise_sat = (w_sum >= {1'b0, r_cfg_max});
    assign w_fall_sat = ($signed(w_diff) <= $signed({1'b0, r_cfg_min}));

    pwm_dwell_timer #(.D(D)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .load_value (w_load_value),
        .enable     (1'b1),
        .zero       (w_zero)
    );

    // Configuration capture; only possible while idle, retained across runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_period <= '0;
            r_cfg_min    <= '0;
            r_cfg_max    <= '0;
            r_cfg_step   <= '0;
            r_cfg_dwell  <= '0;
            r_cfg_hold   <= '0;
        end else if (w_accept) begin
            r_cfg_period <= cfg_period;
            r_cfg_min    <= cfg_duty_min;
            r_cfg_max    <= w_max_in;
            r_cfg_step   <= w_step_in;
            r_cfg_dwell  <= cfg_dwell;
            r_cfg_hold   <= cfg_hold;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next outputs and timer reloads; each state acts when the timer reads zero.
    always_comb begin
        w_state_nxt        = r_state;
        w_period_nxt       = r_period;
        w_duty_nxt         = r_duty;
        w_done_nxt         = 1'b0;
        w_stop_pending_nxt = r_stop_pending;
        w_load             = 1'b0;
        w_load_value       = r_cfg_dwell;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt  = ST_RISE;
                    w_duty_nxt   = r_cfg_min;
                    w_period_nxt = r_cfg_period;
                    w_load       = 1'b1;
                end
            end
            ST_RISE: begin
                if (w_zero) begin
                    w_load = 1'b1;
                    if (w_rise_sat) begin
                        w_state_nxt  = ST_HOLD_HI;
                        w_duty_nxt   = r_cfg_max;
                        w_load_value = r_cfg_hold;
                    end else begin
                        w_duty_nxt = w_sum[N-1:0];
                    end
                end
            end
            ST_HOLD_HI: begin
                if (w_zero) begin
                    w_state_nxt = ST_FALL;
                    w_load      = 1'b1;
                end
            end
            ST_FALL: begin
                if (w_zero) begin
                    w_load = 1'b1;
                    if (w_fall_sat) begin
                        w_state_nxt  = ST_HOLD_LO;
                        w_duty_nxt   = r_cfg_min;
                        w_load_value = r_cfg_hold;
                    end else begin
                        w_duty_nxt = w_diff[N-1:0];
                    end
                end
            end
            ST_HOLD_LO: begin
                if (w_zero) begin
                    w_done_nxt = 1'b1;
                    if (r_stop_pending || stop) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RISE;
                        w_load      = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (r_state != ST_IDLE) begin
            if (stop) begin
                w_stop_pending_nxt = 1'b1;
            end
            if (abort) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b0;
            end
        end

        // Every path into idle parks the generator and drops any pending stop.
        if (w_state_nxt == ST_IDLE) begin
            w_period_nxt       = '0;
            w_duty_nxt         = N'(DUTY_PARK);
            w_stop_pending_nxt = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period       <= '0;
            r_duty         <= N'(DUTY_PARK);
            r_busy         <= 1'b0;
            r_cycle_done   <= 1'b0;
            r_cfg_ready    <= 1'b1;
            r_stop_pending <= 1'b0;
        end else begin
            r_period       <= w_period_nxt;
            r_duty         <= w_duty_nxt;
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_cycle_done   <= w_done_nxt;
            r_cfg_ready    <= (w_state_nxt == ST_IDLE);
            r_stop_pending <= w_stop_pending_nxt;
        end
    end

    assign period     = r_period;
    assign duty       = r_duty;
    assign busy       = r_busy;
    assign cycle_done = r_cycle_done;
    assign cfg_ready  = r_cfg_ready;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [15:0] cfg_duty_min;
    logic [15:0] cfg_duty_max;
    logic [15:0] cfg_step;
    logic [23:0] cfg_dwell;
    logic [23:0] cfg_hold;
    logic        start;
    logic        stop;
    logic        abort;
    logic [15:0] period;
    logic [15:0] duty;
    logic        busy;
    logic        cycle_done;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.N(16), .D(24)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_duty_min (cfg_duty_min),
        .cfg_duty_max (cfg_duty_max),
        .cfg_step     (cfg_step),
        .cfg_dwell    (cfg_dwell),
        .cfg_hold     (cfg_hold),
        .start        (start),
        .stop         (stop),
        .abort        (abort),
        .period       (period),
        .duty         (duty),
        .busy         (busy),
        .cycle_done   (cycle_done)
    );

    // One record: cycle offset after start, controls to drive then, outputs required then.
    typedef struct {
        int          t;
        bit          drv_stop;
        bit          drv_abort;
        logic [15:0] duty;
        bit          done;
        bit          busy;
        logic [15:0] period;
    } vec_t;

    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input int t, input bit s, input bit a, input logic [15:0] d,
                       input bit dn, input bit b, input logic [15:0] p);
        vec_t v;
        v.t = t; v.drv_stop = s; v.drv_abort = a;
        v.duty = d; v.done = dn; v.busy = b; v.period = p;
        sb.push_back(v);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " period"}, 32'(period), 32'h0);
        chk({tag, " duty"}, 32'(duty), 32'hFFFF);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'h1);
        chk({tag, " cycle_done"}, 32'(cycle_done), 32'h0);
    endtask

    task automatic send_cfg(input logic [15:0] p, input logic [15:0] mn, input logic [15:0] mx,
                            input logic [15:0] st, input logic [23:0] dw, input logic [23:0] hd);
        @(negedge clk);
        chk("cfg_ready before offer", 32'(cfg_ready), 32'h1);
        cfg_period = p; cfg_duty_min = mn; cfg_duty_max = mx;
        cfg_step = st; cfg_dwell = dw; cfg_hold = hd;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Pulse start for one edge, then walk the queued expectations cycle by cycle.
    task automatic play(input string tag, input int kmax);
        vec_t e;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0; abort = 1'b0;
            while (sb.size() > 0 && sb[0].t == k) begin
                e = sb.pop_front();
                chk($sformatf("%s t%0d duty", tag, k), 32'(duty), 32'(e.duty));
                chk($sformatf("%s t%0d cycle_done", tag, k), 32'(cycle_done), 32'(e.done));
                chk($sformatf("%s t%0d busy", tag, k), 32'(busy), 32'(e.busy));
                chk($sformatf("%s t%0d period", tag, k), 32'(period), 32'(e.period));
                if (e.drv_stop)  stop  = 1'b1;
                if (e.drv_abort) abort = 1'b1;
            end
        end
        chk($sformatf("%s unreached entries", tag), 32'(sb.size()), 32'h0);
        sb.delete();
        @(negedge clk);
        stop = 1'b0; abort = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0;
        cfg_period = '0; cfg_duty_min = '0; cfg_duty_max = '0;
        cfg_step = '0; cfg_dwell = '0; cfg_hold = '0;
        repeat (3) @(posedge clk);
        #1 idle_chk("reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) idle_chk("after reset");

        // Nominal profile, then abort out of the repeated RISE.
        send_cfg(16'd100, 16'd10, 16'd40, 16'd10, 24'd2, 24'd1);
        add(1, 0, 0, 16'd10, 0, 1, 16'd100);
        add(3, 0, 0, 16'd10, 0, 1, 16'd100);
        add(4, 0, 0, 16'd20, 0, 1, 16'd100);
        add(7, 0, 0, 16'd30, 0, 1, 16'd100);
        add(10, 0, 0, 16'd40, 0, 1, 16'd100);
        add(12, 0, 0, 16'd40, 0, 1, 16'd100);
        add(15, 0, 0, 16'd30, 0, 1, 16'd100);
        add(18, 0, 0, 16'd20, 0, 1, 16'd100);
        add(21, 0, 0, 16'd10, 0, 1, 16'd100);
        add(22, 0, 0, 16'd10, 0, 1, 16'd100);
        add(23, 0, 0, 16'd10, 1, 1, 16'd100);
        add(24, 0, 0, 16'd10, 0, 1, 16'd100);
        add(26, 0, 1, 16'd20, 0, 1, 16'd100);
        add(27, 0, 0, 16'hFFFF, 0, 0, 16'd0);
        play("nominal", 27);

        // Clamp at a max that is not a step multiple.
        send_cfg(16'd7, 16'd10, 16'd35, 16'd10, 24'd0, 24'd0);
        add(1, 0, 0, 16'd10, 0, 1, 16'd7);
        add(2, 0, 0, 16'd20, 0, 1, 16'd7);
        add(3, 0, 0, 16'd30, 0, 1, 16'd7);
        add(4, 0, 0, 16'd35, 0, 1, 16'd7);
        add(5, 0, 0, 16'd35, 0, 1, 16'd7);
        add(6, 0, 0, 16'd25, 0, 1, 16'd7);
        add(7, 0, 0, 16'd15, 0, 1, 16'd7);
        add(8, 0, 0, 16'd10, 0, 1, 16'd7);
        add(9, 0, 0, 16'd10, 1, 1, 16'd7);
        add(10, 0, 1, 16'd20, 0, 1, 16'd7);
        add(11, 0, 0, 16'hFFFF, 0, 0, 16'd0);
        play("clamp35", 11);

        // Full-range steps must not wrap in either direction.
        send_cfg(16'd1, 16'd0, 16'hFFFF, 16'h8000, 24'd0, 24'd0);
        add(1, 0, 0, 16'h0000, 0, 1, 16'd1);
        add(2, 0, 0, 16'h8000, 0, 1, 16'd1);
        add(3, 0, 0, 16'hFFFF, 0, 1, 16'd1);
        add(4, 0, 0, 16'hFFFF, 0, 1, 16'd1);
        add(5, 0, 0, 16'h7FFF, 0, 1, 16'd1);
        add(6, 0, 0, 16'h0000, 0, 1, 16'd1);
        add(7, 0, 1, 16'h0000, 1, 1, 16'd1);
        add(8, 0, 0, 16'hFFFF, 0, 0, 16'd0);
        play("nowrap", 8);

        // Graceful stop requested mid-RISE exits after the low hold.
        send_cfg(16'd100, 16'd10, 16'd40, 16'd10, 24'd2, 24'd1);
        add(2, 1, 0, 16'd10, 0, 1, 16'd100);
        add(4, 0, 0, 16'd20, 0, 1, 16'd100);
        add(12, 0, 0, 16'd40, 0, 1, 16'd100);
        add(21, 0, 0, 16'd10, 0, 1, 16'd100);
        add(22, 0, 0, 16'd10, 0, 1, 16'd100);
        add(23, 0, 0, 16'hFFFF, 1, 0, 16'd0);
        add(24, 0, 0, 16'hFFFF, 0, 0, 16'd0);
        play("stop", 24);
        idle_chk("stop idle");

        // Abort in HOLD_HI, then a fresh start begins at duty_min.
        add(10, 0, 1, 16'd40, 0, 1, 16'd100);
        add(11, 0, 0, 16'hFFFF, 0, 0, 16'd0);
        add(12, 0, 0, 16'hFFFF, 0, 0, 16'd0);
        play("abort_hold", 12);
        add(1, 0, 0, 16'd10, 0, 1, 16'd100);
        add(4, 0, 1, 16'd20, 0, 1, 16'd100);
        add(5, 0, 0, 16'hFFFF, 0, 0, 16'd0);
        play("restart", 5);

        // Config and start together: config taken, start dropped; zero step becomes 1.
        @(negedge clk);
        cfg_period = 16'd200; cfg_duty_min = 16'd5; cfg_duty_max = 16'd8;
        cfg_step = 16'd0; cfg_dwell = 24'd0; cfg_hold = 24'd0;
        cfg_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b0;
        chk("cfg+start busy", 32'(busy), 32'h0);
        chk("cfg+start duty", 32'(duty), 32'hFFFF);
        @(negedge clk);
        chk("cfg+start busy later", 32'(busy), 32'h0);
        add(1, 0, 0, 16'd5, 0, 1, 16'd200);
        add(2, 0, 0, 16'd6, 0, 1, 16'd200);
        add(3, 0, 0, 16'd7, 0, 1, 16'd200);
        add(4, 0, 0, 16'd8, 0, 1, 16'd200);
        add(5, 0, 0, 16'd8, 0, 1, 16'd200);
        add(6, 0, 0, 16'd7, 0, 1, 16'd200);
        add(7, 0, 0, 16'd6, 0, 1, 16'd200);
        add(8, 0, 0, 16'd5, 0, 1, 16'd200);
        add(9, 0, 1, 16'd5, 1, 1, 16'd200);
        add(10, 0, 0, 16'hFFFF, 0, 0, 16'd0);
        play("step0", 10);

        // Inverted bounds give a flat profile; done every 4*(dwell+1) clocks.
        send_cfg(16'd9, 16'd50, 16'd20, 16'd3, 24'd1, 24'd1);
        add(1, 0, 0, 16'd50, 0, 1, 16'd9);
        add(5, 0, 0, 16'd50, 0, 1, 16'd9);
        add(8, 0, 0, 16'd50, 0, 1, 16'd9);
        add(9, 0, 0, 16'd50, 1, 1, 16'd9);
        add(10, 0, 0, 16'd50, 0, 1, 16'd9);
        add(16, 0, 0, 16'd50, 0, 1, 16'd9);
        add(17, 0, 1, 16'd50, 1, 1, 16'd9);
        add(18, 0, 0, 16'hFFFF, 0, 0, 16'd0);
        play("flat", 18);

        // Asynchronous reset in the middle of RISE; config registers cleared too.
        send_cfg(16'd100, 16'd10, 16'd40, 16'd10, 24'd2, 24'd1);
        add(1, 0, 0, 16'd10, 0, 1, 16'd100);
        add(3, 0, 0, 16'd10, 0, 1, 16'd100);
        play("pre_reset", 3);
        #2 rst_n = 1'b0;
        #1 idle_chk("async reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        add(1, 0, 0, 16'd0, 0, 1, 16'd0);
        add(2, 0, 1, 16'd0, 0, 1, 16'd0);
        add(3, 0, 0, 16'hFFFF, 0, 0, 16'd0);
        play("cleared_cfg", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Sequencer that drives the period/duty inputs of the team's accumulator-style pwm generator.
- The generator steps its accumulator by period each clock and outputs high while accumulator >= duty.
- This block produces a repeating "breathing" profile: ramp duty from duty_min up to duty_max, hold, ramp back down, hold, repeat.
- Configuration arrives over a valid/ready port; start/stop/abort control the sequence.

Parameters:
N, 16, width of period, duty and step values (matches pwm N)
D, 24, width of dwell/hold cycle counters

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration can be accepted (IDLE only)
cfg_period  in  N  accumulator step passed to pwm while active
cfg_duty_min  in  N  lower duty bound
cfg_duty_max  in  N  upper duty bound
cfg_step  in  N  duty increment/decrement per ramp step
cfg_dwell  in  D  ramp step interval minus one, in clocks
cfg_hold  in  D  hold time at each extreme minus one, in clocks
start  in  1  begin sequence (level sampled, IDLE only)
stop  in  1  graceful stop request
abort  in  1  immediate stop
period  out  N  to pwm.period
duty  out  N  to pwm.duty
busy  out  1  high in any state other than IDLE
cycle_done  out  1  one-clock pulse per completed up/down cycle

Behaviour:
- Reset (asynchronous, active-low on rst_n): state IDLE; period=0; duty=2^N-1; busy=0; cycle_done=0; cfg_ready=1; all config registers 0; stop_pending=0. Reset mid-sequence forces these values immediately.
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO. The state is registered; all outputs are registered.
- Config accept: cfg_valid & cfg_ready, captured on that edge. cfg_ready = (state==IDLE).
  - If cfg_duty_min > cfg_duty_max, the stored max equals min, giving a flat profile.
  - A stored step of 0 is replaced by 1.
- start in IDLE with no accept in the same cycle: next cycle state=RISE, duty=duty_min, period=cfg period, busy=1, counter=dwell.
- start in the same cycle as a config accept is ignored. start outside IDLE is ignored.
- Counter: loaded on state entry. It decrements each clock, and the state's action fires in the cycle it reads 0. Ramp steps therefore occur every dwell+1 clocks and holds last hold+1 clocks.
- RISE action:
  - next = duty + step, computed in N+1 bits with no wrap.
  - If next >= duty_max: duty=duty_max, go HOLD_HI with counter=hold.
  - Otherwise duty=next and reload counter=dwell.
- HOLD_HI action: go FALL with counter=dwell; duty unchanged.
- FALL action:
  - next = duty - step, computed in N+1 bits signed.
  - If next <= duty_min: duty=duty_min, go HOLD_LO with counter=hold.
  - Otherwise duty=next and reload counter=dwell.
- HOLD_LO action:
  - cycle_done=1 for exactly the next clock.
  - If stop_pending or stop is high this cycle: go IDLE.
  - Otherwise go RISE with counter=dwell; duty stays duty_min.
- Flat profile (min==max): RISE saturates on its first action; the sequence still walks through all states.
- stop in any active state sets stop_pending. Exit happens only at the HOLD_LO action. stop in IDLE is ignored.
- abort (highest priority, any active state): next cycle state=IDLE with IDLE output values; cycle_done=0; stop_pending cleared.
- Entering IDLE by any path:
  - period=0 and duty=2^N-1, which parks the generator low.
  - busy=0, stop_pending=0; config registers retained.
- Priority order: rst_n > abort > cfg accept > start > stop.

Decomposition:
- Shared package pwm_pkg holds:
  - state enumeration (5 states, 3-bit encoding);
  - localparam DUTY_PARK = all ones;
  - default N and D.
- One natural sub-module: pwm_dwell_timer. It is a D-bit loadable down-counter with inputs load, load_value, enable and output zero flag; it is instantiated once.
- The pwm generator itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks, also pulsing it mid-RISE -> period=0, duty=0xFFFF, busy=0, cfg_ready=1 immediately on assertion.
- Nominal profile: config period=100, min=10, max=40, step=10, dwell=2, hold=1; start sampled at edge t0.
  - duty=10 @t0+1, 20 @t0+4, 30 @t0+7, 40 @t0+10.
  - FALL entered @t0+12; duty=30 @t0+15, 20 @t0+18, 10 @t0+21.
  - cycle_done=1 only @t0+23; the ramp then repeats.
- Saturation/clamp: min=10, max=35, step=10 -> up sequence 10, 20, 30, 35 then down 25, 15, 10. Check the same with min=0, max=0xFFFF, step=0x8000: no wrap, duty=0xFFFF then 0x7FFF then 0.
- Graceful stop: assert stop for 1 clock mid-RISE -> profile completes, cycle_done pulses, next clock IDLE with duty=0xFFFF, period=0, busy=0.
- Abort: assert abort in HOLD_HI -> next clock IDLE, no cycle_done; a new start then restarts at duty_min.
- Corner config:
  - cfg_valid with start in the same cycle -> config taken, start ignored, busy stays 0.
  - cfg_step=0 -> steps of 1.
  - min=50, max=20 -> flat duty=50; cycle_done every 4*(dwell+1) clocks with dwell=hold.
